// File: rtl/apb4_arb_pkg.sv
// Shared types and sizing helpers for the APB4 master arbiter.
package apb4_arb_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} arb_state_e;

  localparam int TIMEOUT_CYCLES_DEF = 16;
  localparam int TO_W = $clog2(TIMEOUT_CYCLES_DEF + 1);

  // Wait-counter width for a given timeout; stays >= 1 so a disabled timeout still sizes cleanly.
  function automatic int cnt_w(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/apb4_rr_arbiter.sv
// Round-robin one-hot grant; the pointer owns last-served index and advances only on accept.
module apb4_rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               accept_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      gnt_idx_o,
  output logic               any_o
);

  logic [IW-1:0] last_q;
  int            idx;

  // Search last+1 .. last+NUM_REQ (mod NUM_REQ); the first hit wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    idx       = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = 32'(last_q) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           last_q <= IW'(NUM_REQ - 1);
    else if (accept_i) last_q <= gnt_idx_o;
  end

endmodule

// File: rtl/apb4_master_arbiter.sv
// Shares one APB4 master port among NUM_REQ requesters: RR accept in IDLE, SETUP/ACCESS
// phasing, wait-state absorption and timeout abort, with a registered one-cycle response.
module apb4_master_arbiter
  import apb4_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 3,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          psel,
  output logic                          penable,
  output logic                          pwrite,
  output logic [ADDR_WIDTH-1:0]         paddr,
  output logic [DATA_WIDTH-1:0]         pwdata,
  output logic [DATA_WIDTH/8-1:0]       pstrb,
  input  logic [DATA_WIDTH-1:0]         prdata,
  input  logic                          pready,
  input  logic                          pslverr
);

  localparam int IW  = $clog2(NUM_REQ);
  localparam int CW  = cnt_w(TIMEOUT_CYCLES);
  localparam int LIM = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  arb_state_e            state_q, state_d;
  logic                  psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [NUM_REQ-1:0]    own_q, own_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0]    gnt;
  logic [IW-1:0]         gnt_idx;
  logic                  any, accept;
  logic                  w_sel;
  logic [ADDR_WIDTH-1:0] a_sel;
  logic [DATA_WIDTH-1:0] d_sel;

  apb4_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_valid),
    .accept_i  (accept),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (any)
  );

  always_comb begin
    w_sel = 1'b0;
    a_sel = '0;
    d_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        w_sel = req_write[i];
        a_sel = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        d_sel = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    own_d       = own_q;
    cnt_d       = cnt_q;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    req_ready   = '0;
    accept      = 1'b0;
    case (state_q)
      IDLE: if (any) begin
        accept    = 1'b1;
        req_ready = gnt;
        pwrite_d  = w_sel;
        paddr_d   = a_sel;
        pwdata_d  = d_sel;
        own_d     = gnt;
        psel_d    = 1'b1;
        cnt_d     = '0;
        state_d   = SETUP;
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = own_q;
          rsp_err_d   = pslverr;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          state_d     = IDLE;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == CW'(LIM)) begin
          // Abort: the slave never answered, report an error with no data.
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = own_q;
          rsp_err_d   = 1'b1;
          state_d     = IDLE;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      own_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      own_q       <= own_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = '1;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb4_master_arbiter.sv
// Directed bench: arbiter driving a small APB register-file stub with programmable stalls/errors.
module tb_apb4_master_arbiter;

  localparam int N = 2, AW = 3, DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_write, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0] rsp_rdata, pwdata, prdata;
  logic          rsp_err, psel, penable, pwrite, pready, pslverr;
  logic [AW-1:0] paddr;
  logic [DW/8-1:0] pstrb;

  logic [DW-1:0] mem [8];
  logic [7:0]    wcnt, stall_n;
  logic          hang, err_en;
  int            pas, tot;

  always #5 clk = ~clk;

  apb4_master_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  assign pready  = psel && penable && !hang && (wcnt == stall_n);
  assign pslverr = err_en && pready;
  assign prdata  = mem[paddr];

  always @(posedge clk) begin
    if (psel && penable && !pready) wcnt <= wcnt + 8'd1;
    else                            wcnt <= 8'd0;
    if (psel && penable && pready && pwrite) mem[paddr] <= pwdata;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write[i] = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req_valid[i] = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step();
    tot++; if ({psel, penable, pwrite} !== 3'b000) $display("FAIL reset_ctrl got %b exp 000", {psel, penable, pwrite}); else pas++;
    tot++; if (paddr !== '0 || pwdata !== '0) $display("FAIL reset_addr_data got %0h/%0h exp 0/0", paddr, pwdata); else pas++;
    tot++; if (rsp_valid !== 2'b00 || rsp_err !== 1'b0 || rsp_rdata !== '0) $display("FAIL reset_rsp got %b/%b/%0h exp 00/0/0", rsp_valid, rsp_err, rsp_rdata); else pas++;
    tot++; if (pstrb !== 4'hf) $display("FAIL reset_pstrb got %0h exp f", pstrb); else pas++;
    rst = 1'b0; step();
  endtask

  task automatic test_write_read();
    drive(0, 1'b1, 3'd0, 32'hEF);
    tot++; if (req_ready !== 2'b01) $display("FAIL t1_ready got %b exp 01", req_ready); else pas++;
    step(); req_valid = '0; #1;
    tot++; if ({psel, penable, pwrite} !== 3'b101) $display("FAIL t1_setup got %b exp 101", {psel, penable, pwrite}); else pas++;
    tot++; if (req_ready !== 2'b00) $display("FAIL t1_ready_setup got %b exp 00", req_ready); else pas++;
    step();
    tot++; if ({psel, penable} !== 2'b11 || paddr !== 3'd0 || pwdata !== 32'hEF) $display("FAIL t1_access got %b a=%0h d=%0h exp 11 a=0 d=ef", {psel, penable}, paddr, pwdata); else pas++;
    step();
    tot++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || rsp_rdata !== '0 || psel !== 1'b0) $display("FAIL t1_wrsp got v=%b e=%b r=%0h s=%b exp v=01 e=0 r=0 s=0", rsp_valid, rsp_err, rsp_rdata, psel); else pas++;
    step();
    tot++; if (rsp_valid !== 2'b00) $display("FAIL t1_pulse got %b exp 00", rsp_valid); else pas++;
    drive(1, 1'b0, 3'd0, 32'h0);
    tot++; if (req_ready !== 2'b10) $display("FAIL t1_rd_ready got %b exp 10", req_ready); else pas++;
    step(); req_valid = '0; step(); step();
    tot++; if (rsp_valid !== 2'b10 || rsp_rdata !== 32'hEF || rsp_err !== 1'b0) $display("FAIL t1_rd got v=%b r=%0h e=%b exp v=10 r=ef e=0", rsp_valid, rsp_rdata, rsp_err); else pas++;
    step();
    tot++; if (rsp_rdata !== '0 || rsp_err !== 1'b0) $display("FAIL t1_rd_clear got r=%0h e=%b exp 0/0", rsp_rdata, rsp_err); else pas++;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g;
    int waited;
    req_write = 2'b11;
    req_addr  = {3'd2, 3'd1};
    req_wdata = {32'h22, 32'h11};
    req_valid = 2'b11; #1;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      waited = 0;
      while (req_ready === 2'b00 && waited < 10) begin step(); waited++; end
      tot++; if (req_ready !== exp_g) $display("FAIL rr_grant%0d got %b exp %b", k, req_ready, exp_g); else pas++;
      if (k > 0) begin
        tot++; if (waited != 0) $display("FAIL rr_b2b%0d got %0d idle cycles exp 0", k, waited); else pas++;
      end
      step(); step(); step();
      tot++; if (rsp_valid !== exp_g) $display("FAIL rr_rsp%0d got %b exp %b", k, rsp_valid, exp_g); else pas++;
    end
    req_valid = '0; step();
  endtask

  task automatic test_wait_states();
    stall_n = 8'd3;
    drive(0, 1'b1, 3'd3, 32'h1234);
    step(); req_valid = '0; step();
    for (int c = 0; c < 4; c++) begin
      tot++; if (penable !== 1'b1 || paddr !== 3'd3 || pwdata !== 32'h1234 || rsp_valid !== 2'b00) $display("FAIL ws_hold%0d got en=%b a=%0h d=%0h v=%b exp en=1 a=3 d=1234 v=00", c, penable, paddr, pwdata, rsp_valid); else pas++;
      step();
    end
    tot++; if (rsp_valid !== 2'b01 || penable !== 1'b0) $display("FAIL ws_rsp got v=%b en=%b exp v=01 en=0", rsp_valid, penable); else pas++;
    stall_n = 8'd0; step();
  endtask

  task automatic test_timeout();
    hang = 1'b1;
    drive(1, 1'b0, 3'd0, 32'h0);
    step(); req_valid = '0; step();
    for (int c = 0; c < 16; c++) begin
      if (penable !== 1'b1 || rsp_valid !== 2'b00) begin
        tot++; $display("FAIL to_access%0d got en=%b v=%b exp en=1 v=00", c, penable, rsp_valid);
      end
      step();
    end
    tot++; if (rsp_valid !== 2'b10 || rsp_err !== 1'b1 || rsp_rdata !== '0 || psel !== 1'b0 || penable !== 1'b0) $display("FAIL to_abort got v=%b e=%b r=%0h s=%b en=%b exp v=10 e=1 r=0 s=0 en=0", rsp_valid, rsp_err, rsp_rdata, psel, penable); else pas++;
    hang = 1'b0; step();
    tot++; if (rsp_err !== 1'b0) $display("FAIL to_err_clear got %b exp 0", rsp_err); else pas++;
    drive(0, 1'b0, 3'd3, 32'h0);
    step(); req_valid = '0; step(); step();
    tot++; if (rsp_valid !== 2'b01 || rsp_rdata !== 32'h1234 || rsp_err !== 1'b0) $display("FAIL to_next got v=%b r=%0h e=%b exp v=01 r=1234 e=0", rsp_valid, rsp_rdata, rsp_err); else pas++;
    step();
  endtask

  task automatic test_slverr();
    err_en = 1'b1;
    drive(1, 1'b0, 3'd3, 32'h0);
    step(); req_valid = '0; step(); step();
    tot++; if (rsp_valid !== 2'b10 || rsp_err !== 1'b1 || rsp_rdata !== 32'h1234) $display("FAIL se_rsp got v=%b e=%b r=%0h exp v=10 e=1 r=1234", rsp_valid, rsp_err, rsp_rdata); else pas++;
    err_en = 1'b0; step();
  endtask

  task automatic test_reset_mid();
    stall_n = 8'd5;
    drive(0, 1'b1, 3'd6, 32'h77);
    step(); req_valid = '0; step();
    tot++; if (penable !== 1'b1) $display("FAIL rm_access got %b exp 1", penable); else pas++;
    rst = 1'b1; step();
    tot++; if ({psel, penable} !== 2'b00 || rsp_valid !== 2'b00) $display("FAIL rm_drop got ctl=%b v=%b exp 00/00", {psel, penable}, rsp_valid); else pas++;
    rst = 1'b0; stall_n = 8'd0;
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid !== 2'b00 || psel !== 1'b0) begin
        tot++; $display("FAIL rm_quiet%0d got v=%b s=%b exp 00/0", c, rsp_valid, psel);
      end
      step();
    end
    req_write = 2'b00; req_addr = '0; req_valid = 2'b11; #1;
    tot++; if (req_ready !== 2'b01) $display("FAIL rm_ptr got %b exp 01", req_ready); else pas++;
    step(); req_valid = '0; step(); step();
    tot++; if (rsp_valid !== 2'b01) $display("FAIL rm_rsp got %b exp 01", rsp_valid); else pas++;
    step();
  endtask

  initial begin
    pas = 0; tot = 0;
    rst = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    stall_n = 8'd0; hang = 1'b0; err_en = 1'b0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_wait_states();
    test_timeout();
    test_slverr();
    test_reset_mid();
    $display("%0d/%0d checks passed", pas, tot);
    $finish;
  end

endmodule
